mem_unit: RTL and testbench
===========================

Name: mem_unit

Overview:
- Memory stage directly downstream of the load/store control FSMs.
- Holds MAR and MDR, a single-port RAM array, and the MEM_EN/MEM_RW/MFC access handshake.
- The FSMs drive register-transfer strobes; mem_unit latches bus values, performs the timed access, and drives MFC as the in-flight flag that the FSM wait states poll.

Parameters:
- DATA_W, 16, width of bus, MDR and RAM words.
- ADDR_W, 8, width of MAR; RAM depth is 2**ADDR_W.
- LATENCY, 2, cycles MFC stays high per access; legal range 1..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- bus_in  in  DATA_W  internal CPU bus value.
- MAR_write  in  1  MAR <= bus_in[ADDR_W-1:0].
- MAR_mem_read  in  1  MAR <= MDR[ADDR_W-1:0] (indirect address).
- MDR_write  in  1  MDR <= bus_in.
- MDR_mem_read  in  1  write-data enable; must be 1 with MEM_EN for a store to modify RAM.
- MDR_read  in  1  drive MDR onto bus_out.
- MEM_EN  in  1  access request, sampled in IDLE only.
- MEM_RW  in  1  1 = read (RAM -> MDR), 0 = write (MDR -> RAM).
- MFC  out  1  high while an access is in flight.
- bus_out  out  DATA_W  MDR value when bus_oe is 1, else 0.
- bus_oe  out  1  equals MDR_read (combinational).
- ovr  out  1  one-cycle pulse: MEM_EN seen while busy.
- mar_q  out  ADDR_W  current MAR.
- mdr_q  out  DATA_W  current MDR.

Behaviour:
- Reset (sync): state IDLE, MAR=0, MDR=0, MFC=0, ovr=0, counter=0.
  - RAM contents are not cleared, except when MEM_CLEAR_EN is defined.
- Reset mid-access aborts the access: no RAM write and no MDR load.
- States:
  - IDLE: if MEM_EN=1 at an edge, snapshot op (MEM_RW), address (MAR), write data (MDR) and write-enable (MDR_mem_read); set cnt=LATENCY-1; MFC<=1; go BUSY.
  - BUSY: if cnt!=0, cnt<=cnt-1. If cnt==0, complete the access, MFC<=0, go IDLE.
    - Read completion: MDR <= RAM[snap_addr].
    - Write completion: if snap_we=1, RAM[snap_addr] <= snap_data; otherwise no RAM change.
- Timing: MEM_EN sampled at edge T → MFC high for exactly LATENCY cycles, low after edge T+LATENCY. Read data is visible on mdr_q in the cycle after MFC falls.
- Priorities:
  - MAR_write and MAR_mem_read on the same edge: MAR_write wins.
  - MDR_write on the read-completion edge: RAM data wins and MDR_write is dropped.
  - MAR/MDR writes during BUSY update the registers but not the in-flight snapshot.
- MEM_EN in BUSY is ignored, and ovr pulses the following cycle.
- MEM_EN in the completion cycle (cnt==0) is also ignored; no back-to-back accept.
- MAR_mem_read uses the MDR value before any same-edge MDR update.
- Address wraps naturally; there is no out-of-range check.

Optional Feature:
- Macro: MEM_CLEAR_EN.
- Defined:
  - After reset deassert, the block enters state CLEAR and writes 0 to addresses 0..2**ADDR_W-1, one per cycle.
  - MFC is held 1 throughout the clear.
  - MEM_EN during CLEAR is ignored and pulses ovr.
  - The block returns to IDLE after the last address.
  - Reset during CLEAR restarts the clear at address 0.
- Undefined: no CLEAR state; RAM is uninitialised after reset.

Test Plan:
- Reset, then bus_in=0x0012 with MAR_write, bus_in=0xBEEF with MDR_write, then MEM_EN with MEM_RW=0 and MDR_mem_read=1 → MFC=1 for 2 cycles, then RAM[0x12]=0xBEEF.
- Read: MDR_write 0x0000, MAR=0x12, MEM_EN with MEM_RW=1 → MFC high 2 cycles; mdr_q=0xBEEF next cycle; MDR_read=1 gives bus_out=0xBEEF and bus_oe=1.
- Store with MDR_mem_read=0 to 0x12 (MDR=0x1111) → MFC still pulses for 2 cycles, and RAM[0x12] stays 0xBEEF.
- MEM_EN re-asserted during BUSY, plus MAR_write 0x40 mid-access → ovr pulses once; the access completes to the snapshot address 0x12; mar_q=0x40.
- Reset asserted on the 1st BUSY cycle of a write of 0x5555 to 0x20 → MFC=0 next cycle, RAM[0x20] unchanged, MAR=MDR=0.
- With MEM_CLEAR_EN, ADDR_W=4 → MFC high for 16 cycles after reset; a read of any address then returns 0x0000.

Source files
------------

// File: rtl/mem_unit.sv
// mem_unit: memory stage holding MAR/MDR, a single-port RAM and the
// MEM_EN/MEM_RW/MFC access handshake. Each access is snapshotted on accept,
// so the FSMs may keep updating MAR/MDR while MFC is high.
// Optional feature macro: MEM_CLEAR_EN (zero the RAM after every reset).
module mem_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MAR_write,
    input  logic              MAR_mem_read,
    input  logic              MDR_write,
    input  logic              MDR_mem_read,
    input  logic              MDR_read,
    input  logic              MEM_EN,
    input  logic              MEM_RW,
    output logic              MFC,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              ovr,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q
);

    localparam int unsigned Depth   = 1 << ADDR_W;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

`ifdef MEM_CLEAR_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1, StClear = 2'd2} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StBusy = 2'd1} state_e;
`endif

    state_e              r_state;
    state_e              w_state_d;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_d;
    logic                r_mfc;
    logic                w_mfc_d;
    logic                r_ovr;
    logic                w_ovr_d;
    logic                w_accept;
    logic                w_complete;

    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_snap_rw;
    logic                r_snap_we;
    logic [ADDR_W-1:0]   r_snap_addr;
    logic [DATA_W-1:0]   r_snap_data;

    logic [DATA_W-1:0]   r_mem [Depth];
    logic                w_ram_we;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_data;
    logic [DATA_W-1:0]   w_rd_data;

`ifdef MEM_CLEAR_EN
    logic [ADDR_W-1:0]   r_clr_addr;
`endif

    // Next-state logic: accept in IDLE only, count down in BUSY, complete at zero.
    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_mfc_d    = r_mfc;
        w_ovr_d    = 1'b0;
        w_accept   = 1'b0;
        w_complete = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (MEM_EN) begin
                    w_accept  = 1'b1;
                    w_cnt_d   = CntInit;
                    w_mfc_d   = 1'b1;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                // Requests while busy (completion cycle included) are dropped and flagged.
                w_ovr_d = MEM_EN;
                if (r_cnt != 4'd0) begin
                    w_cnt_d = r_cnt - 4'd1;
                end else begin
                    w_complete = 1'b1;
                    w_mfc_d    = 1'b0;
                    w_state_d  = StIdle;
                end
            end
`ifdef MEM_CLEAR_EN
            StClear: begin
                w_ovr_d = MEM_EN;
                w_mfc_d = 1'b1;
                if (&r_clr_addr) begin
                    w_mfc_d   = 1'b0;
                    w_state_d = StIdle;
                end
            end
`endif
            default: begin
                w_state_d = StIdle;
                w_mfc_d   = 1'b0;
            end
        endcase
    end

    // Control state register; MFC comes up with reset when the clear sweep is built in.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef MEM_CLEAR_EN
            r_state <= StClear;
            r_mfc   <= 1'b1;
`else
            r_state <= StIdle;
            r_mfc   <= 1'b0;
`endif
            r_cnt   <= 4'd0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_mfc   <= w_mfc_d;
            r_ovr   <= w_ovr_d;
        end
    end

    // MAR/MDR transfers and the access snapshot taken on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mar       <= '0;
            r_mdr       <= '0;
            r_snap_rw   <= 1'b0;
            r_snap_we   <= 1'b0;
            r_snap_addr <= '0;
            r_snap_data <= '0;
`ifdef MEM_CLEAR_EN
            r_clr_addr  <= '0;
`endif
        end else begin
            // Indirect load reads MDR before any same-edge MDR update.
            if (MAR_write) begin
                r_mar <= bus_in[ADDR_W-1:0];
            end else if (MAR_mem_read) begin
                r_mar <= r_mdr[ADDR_W-1:0];
            end
            // RAM read data beats a same-edge bus write.
            if (w_complete && r_snap_rw) begin
                r_mdr <= w_rd_data;
            end else if (MDR_write) begin
                r_mdr <= bus_in;
            end
            if (w_accept) begin
                r_snap_rw   <= MEM_RW;
                r_snap_we   <= MDR_mem_read;
                r_snap_addr <= r_mar;
                r_snap_data <= r_mdr;
            end
`ifdef MEM_CLEAR_EN
            if (r_state == StClear) begin
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end
`endif
        end
    end

    // RAM write port select; reset on the completion edge aborts the store.
    always_comb begin
        w_ram_we   = w_complete && !r_snap_rw && r_snap_we && !reset;
        w_ram_addr = r_snap_addr;
        w_ram_data = r_snap_data;
`ifdef MEM_CLEAR_EN
        if (r_state == StClear && !reset) begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_clr_addr;
            w_ram_data = '0;
        end
`endif
    end

    // RAM array: contents survive reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_data;
        end
    end

    assign w_rd_data = r_mem[r_snap_addr];

    assign MFC     = r_mfc;
    assign ovr     = r_ovr;
    assign mar_q   = r_mar;
    assign mdr_q   = r_mdr;
    assign bus_oe  = MDR_read;
    assign bus_out = MDR_read ? r_mdr : '0;

endmodule

// File: tb/tb_mem_unit.sv
// Testbench for mem_unit: per-cycle vector table plus short hand sequences.
module tb_mem_unit;

    localparam int DW  = 16;
    localparam int AW  = 8;
    localparam int LAT = 2;

    logic          clk;
    logic          reset;
    logic [DW-1:0] bus_in;
    logic          MAR_write;
    logic          MAR_mem_read;
    logic          MDR_write;
    logic          MDR_mem_read;
    logic          MDR_read;
    logic          MEM_EN;
    logic          MEM_RW;
    logic          MFC;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic          ovr;
    logic [AW-1:0] mar_q;
    logic [DW-1:0] mdr_q;

    mem_unit #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_in       (bus_in),
        .MAR_write    (MAR_write),
        .MAR_mem_read (MAR_mem_read),
        .MDR_write    (MDR_write),
        .MDR_mem_read (MDR_mem_read),
        .MDR_read     (MDR_read),
        .MEM_EN       (MEM_EN),
        .MEM_RW       (MEM_RW),
        .MFC          (MFC),
        .bus_out      (bus_out),
        .bus_oe       (bus_oe),
        .ovr          (ovr),
        .mar_q        (mar_q),
        .mdr_q        (mdr_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          rst;
        logic [DW-1:0] bus;
        logic          maw;
        logic          marr;
        logic          mdw;
        logic          mdmr;
        logic          mdrd;
        logic          en;
        logic          rw;
        logic          mfc;
        logic          ovr;
        logic [AW-1:0] mar;
        logic [DW-1:0] mdr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(input logic rst, input logic [DW-1:0] bus, input logic maw,
                                input logic marr, input logic mdw, input logic mdmr,
                                input logic mdrd, input logic en, input logic rw,
                                input logic e_mfc, input logic e_ovr, input logic [AW-1:0] e_mar,
                                input logic [DW-1:0] e_mdr);
        vec_t v;
        v.rst = rst;  v.bus = bus;   v.maw = maw;   v.marr = marr; v.mdw = mdw;
        v.mdmr = mdmr; v.mdrd = mdrd; v.en = en;    v.rw = rw;
        v.mfc = e_mfc; v.ovr = e_ovr; v.mar = e_mar; v.mdr = e_mdr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset        = v.rst;
        bus_in       = v.bus;
        MAR_write    = v.maw;
        MAR_mem_read = v.marr;
        MDR_write    = v.mdw;
        MDR_mem_read = v.mdmr;
        MDR_read     = v.mdrd;
        MEM_EN       = v.en;
        MEM_RW       = v.rw;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; bus_in = '0; MAR_write = 1'b0; MAR_mem_read = 1'b0; MDR_write = 1'b0;
        MDR_mem_read = 1'b0; MDR_read = 1'b0; MEM_EN = 1'b0; MEM_RW = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
`ifdef MEM_CLEAR_EN
        begin
            int n;
            step();
            step();
            check("clear_mfc_in_reset", 32'(MFC), 32'd1);
            reset  = 1'b0;
            MEM_EN = 1'b1;
            n = MFC ? 1 : 0;
            step();
            MEM_EN = 1'b0;
            check("clear_ovr", 32'(ovr), 32'd1);
            for (int k = 0; k < 2000 && MFC; k++) begin
                n++;
                step();
            end
            check("clear_mfc_width", 32'(n), 32'(1 << AW));
            check("clear_mfc_low", 32'(MFC), 32'd0);
            bus_in = 16'h0037; MAR_write = 1'b1;
            step();
            MAR_write = 1'b0; MEM_EN = 1'b1; MEM_RW = 1'b1;
            step();
            MEM_EN = 1'b0;
            for (int k = 0; k < 40 && MFC; k++) step();
            check("clear_read_zero", 32'(mdr_q), 32'h0);
            check("clear_mar", 32'(mar_q), 32'h37);
        end
`else
        //  rst bus       maw marr mdw mdmr mdrd en rw   mfc ovr mar    mdr
        add(1, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h00, 16'h0000);
        add(1, 16'hFFFF,  1, 0,  1,  0,  0,  1, 0,   0, 0, 8'h00, 16'h0000);
        add(0, 16'h0012,  1, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'h0000);
        add(0, 16'hBEEF,  0, 0,  1,  0,  0,  0, 0,   0, 0, 8'h12, 16'hBEEF);
        add(0, 16'h0000,  0, 0,  0,  1,  0,  1, 0,   1, 0, 8'h12, 16'hBEEF);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   1, 0, 8'h12, 16'hBEEF);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'hBEEF);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'hBEEF);
        // read back 0x12
        add(0, 16'h0000,  0, 0,  1,  0,  0,  0, 0,   0, 0, 8'h12, 16'h0000);
        add(0, 16'h0012,  1, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  1, 1,   1, 0, 8'h12, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   1, 0, 8'h12, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'hBEEF);
        add(0, 16'h0000,  0, 0,  0,  0,  1,  0, 0,   0, 0, 8'h12, 16'hBEEF);
        // store without write enable, then read: RAM unchanged
        add(0, 16'h1111,  0, 0,  1,  0,  0,  0, 0,   0, 0, 8'h12, 16'h1111);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  1, 0,   1, 0, 8'h12, 16'h1111);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   1, 0, 8'h12, 16'h1111);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'h1111);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  1, 1,   1, 0, 8'h12, 16'h1111);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   1, 0, 8'h12, 16'h1111);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'hBEEF);
        // overrun + MAR change mid-access: store goes to snapshot 0x12
        add(0, 16'h5A5A,  0, 0,  1,  0,  0,  0, 0,   0, 0, 8'h12, 16'h5A5A);
        add(0, 16'h0000,  0, 0,  0,  1,  0,  1, 0,   1, 0, 8'h12, 16'h5A5A);
        add(0, 16'h0040,  1, 0,  0,  0,  0,  1, 0,   1, 1, 8'h40, 16'h5A5A);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h40, 16'h5A5A);
        add(0, 16'h0012,  1, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'h5A5A);
        add(0, 16'h0000,  0, 0,  1,  0,  0,  0, 0,   0, 0, 8'h12, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  1, 1,   1, 0, 8'h12, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   1, 0, 8'h12, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'h5A5A);
        // MAR priority and indirect address from pre-edge MDR
        add(0, 16'h0033,  1, 1,  0,  0,  0,  0, 0,   0, 0, 8'h33, 16'h5A5A);
        add(0, 16'h0077,  0, 1,  1,  0,  0,  0, 0,   0, 0, 8'h5A, 16'h0077);
        // read with MDR_write and MEM_EN on the completion edge
        add(0, 16'h0012,  1, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'h0077);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  1, 1,   1, 0, 8'h12, 16'h0077);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   1, 0, 8'h12, 16'h0077);
        add(0, 16'h9999,  0, 0,  1,  0,  0,  1, 1,   0, 1, 8'h12, 16'h5A5A);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h12, 16'h5A5A);
        // preload RAM[0x20]=0x1234, then abort a store of 0x5555 with reset
        add(0, 16'h0020,  1, 0,  0,  0,  0,  0, 0,   0, 0, 8'h20, 16'h5A5A);
        add(0, 16'h1234,  0, 0,  1,  0,  0,  0, 0,   0, 0, 8'h20, 16'h1234);
        add(0, 16'h0000,  0, 0,  0,  1,  0,  1, 0,   1, 0, 8'h20, 16'h1234);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   1, 0, 8'h20, 16'h1234);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h20, 16'h1234);
        add(0, 16'h5555,  0, 0,  1,  0,  0,  0, 0,   0, 0, 8'h20, 16'h5555);
        add(0, 16'h0000,  0, 0,  0,  1,  0,  1, 0,   1, 0, 8'h20, 16'h5555);
        add(1, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h00, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   0, 0, 8'h00, 16'h0000);
        add(0, 16'h0020,  1, 0,  0,  0,  0,  0, 0,   0, 0, 8'h20, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  1, 1,   1, 0, 8'h20, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  0,  0, 0,   1, 0, 8'h20, 16'h0000);
        add(0, 16'h0000,  0, 0,  0,  0,  1,  0, 0,   0, 0, 8'h20, 16'h1234);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            check($sformatf("row%0d mfc", i), 32'(MFC), 32'(vecs[i].mfc));
            check($sformatf("row%0d ovr", i), 32'(ovr), 32'(vecs[i].ovr));
            check($sformatf("row%0d mar", i), 32'(mar_q), 32'(vecs[i].mar));
            check($sformatf("row%0d mdr", i), 32'(mdr_q), 32'(vecs[i].mdr));
            check($sformatf("row%0d bus_oe", i), 32'(bus_oe), 32'(vecs[i].mdrd));
            check($sformatf("row%0d bus_out", i), 32'(bus_out),
                  vecs[i].mdrd ? 32'(vecs[i].mdr) : 32'h0);
        end

        // MFC width for one access equals LATENCY
        begin
            int n;
            idle_inputs();
            MEM_EN = 1'b1; MEM_RW = 1'b1;
            step();
            MEM_EN = 1'b0;
            n = 0;
            for (int k = 0; k < 40 && MFC; k++) begin
                n++;
                step();
            end
            check("mfc_width", 32'(n), 32'(LAT));
            check("mfc_low_after", 32'(MFC), 32'd0);
            check("reread_0x20", 32'(mdr_q), 32'h1234);
        end

        // indirect address takes the low ADDR_W bits of MDR
        idle_inputs();
        bus_in = 16'hABCD; MDR_write = 1'b1;
        step();
        MDR_write = 1'b0; MAR_mem_read = 1'b1;
        step();
        MAR_mem_read = 1'b0;
        check("indirect_wrap", 32'(mar_q), 32'hCD);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
